// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, event kinds,
// cause codes, privilege levels and level-stack sizing.
package trap_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_IRQ,
        EV_ERET
    } event_t;

    localparam logic [2:0] CAUSE_IRQ   = 3'd0;
    localparam logic [2:0] CAUSE_UNDEF = 3'd1;
    localparam logic [2:0] CAUSE_OVF   = 3'd2;
    localparam logic [2:0] CAUSE_RANGE = 3'd4;

    localparam logic [2:0] LVL_USER = 3'd0;
    localparam logic [2:0] LVL_EXC  = 3'd4;

    localparam int STACK_DEPTH = 4;

    // Level requested by the highest active interrupt line (line i -> level i+1).
    function automatic logic [2:0] irq_level(input logic [2:0] lines);
        if (lines[2])      return 3'd3;
        else if (lines[1]) return 3'd2;
        else if (lines[0]) return 3'd1;
        else               return LVL_USER;
    endfunction

    function automatic logic [2:0] level_onehot(input logic [2:0] level);
        case (level)
            3'd1:    return 3'b001;
            3'd2:    return 3'b010;
            3'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline-side bundle of the trap sequencer: event inputs, CP0 values and
// the stall/flush/redirect/CP0-write controls it produces.
interface trap_sequencer_if;
    logic        exc_valid;
    logic [2:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [2:0]  irq_req;
    logic [31:0] int_pc;
    logic        ie;
    logic        eret_req;
    logic [31:0] handler_base;
    logic [31:0] epc_in;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        cp0_we;
    logic [31:0] cp0_epc;
    logic [2:0]  cp0_cause;
    logic [2:0]  irq_ack;
    logic [2:0]  cur_level;
    logic        nest_err;

    modport master (
        output exc_valid, exc_cause, exc_pc, irq_req, int_pc, ie, eret_req,
               handler_base, epc_in,
        input  stall, flush, redirect_valid, redirect_pc, cp0_we, cp0_epc,
               cp0_cause, irq_ack, cur_level, nest_err
    );

    modport slave (
        input  exc_valid, exc_cause, exc_pc, irq_req, int_pc, ie, eret_req,
               handler_base, epc_in,
        output stall, flush, redirect_valid, redirect_pc, cp0_we, cp0_epc,
               cp0_cause, irq_ack, cur_level, nest_err
    );
endinterface

// File: rtl/trap_sequencer_level_stack.sv
// LIFO of saved privilege levels; push is dropped when full, pop when empty.
module level_stack
    import trap_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [2:0] push_data,
    output logic [2:0] top,
    output logic       full,
    output logic       empty
);

    logic [2:0] mem [STACK_DEPTH];
    logic [2:0] count;

    assign full  = (count == 3'(STACK_DEPTH));
    assign empty = (count == 3'd0);
    assign top   = empty ? LVL_USER : mem[count[1:0] - 2'd1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 3'd0;
            for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= LVL_USER;
        end else if (push && !full) begin
            mem[count[1:0]] <= push_data;
            count           <= count + 3'd1;
        end else if (pop && !empty) begin
            count <= count - 3'd1;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer: accepts exceptions, ERETs and prioritised interrupts in IDLE
// and plays out a fixed FLUSH -> REDIRECT sequence with CP0 updates.
module trap_sequencer
    import trap_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    trap_sequencer_if.slave    bus
);

    state_t      state, next_state;
    event_t      ev_sel, ev_q;
    logic        exc_ignored;
    logic [2:0]  irq_lvl;
    logic [2:0]  cause_q;
    logic [2:0]  new_level_q;
    logic [2:0]  cur_level_q;
    logic        nest_err_q;
    logic [31:0] cp0_epc_q;
    logic [31:0] redirect_pc_q;
    logic        push, pop;
    logic [2:0]  stack_top;
    logic        stack_full, stack_empty;

    assign irq_lvl = irq_level(bus.irq_req);

    level_stack u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (cur_level_q),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // An exception raised at the exception level consumes the cycle without
    // starting a sequence; it only flags the nesting error.
    always_comb begin
        next_state  = state;
        ev_sel      = EV_NONE;
        exc_ignored = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.exc_valid && bus.ie) begin
                    if (cur_level_q == LVL_EXC) exc_ignored = 1'b1;
                    else                        ev_sel      = EV_EXC;
                end else if (bus.eret_req) begin
                    ev_sel = EV_ERET;
                end else if (bus.ie && (irq_lvl > cur_level_q) && !stack_full) begin
                    ev_sel = EV_IRQ;
                end
                if (ev_sel != EV_NONE) next_state = ST_FLUSH;
            end
            ST_FLUSH:    next_state = ST_REDIRECT;
            ST_REDIRECT: next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.stall          = (state != ST_IDLE);
        bus.flush          = (state == ST_FLUSH);
        bus.redirect_valid = (state == ST_REDIRECT);
        bus.cp0_we         = (state == ST_FLUSH) && (ev_q != EV_ERET);
        bus.cp0_cause      = ((state == ST_FLUSH) && (ev_q == EV_EXC)) ? cause_q : CAUSE_IRQ;
        bus.irq_ack        = ((state == ST_FLUSH) && (ev_q == EV_IRQ)) ? level_onehot(new_level_q) : 3'b000;
        push               = (state == ST_REDIRECT) && (ev_q != EV_ERET);
        pop                = (state == ST_REDIRECT) && (ev_q == EV_ERET);
    end

    assign bus.redirect_pc = redirect_pc_q;
    assign bus.cp0_epc     = cp0_epc_q;
    assign bus.cur_level   = cur_level_q;
    assign bus.nest_err    = nest_err_q;

    // Event operands are captured at acceptance; ERET's target is sampled in FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q          <= EV_NONE;
            cause_q       <= CAUSE_IRQ;
            new_level_q   <= LVL_USER;
            cp0_epc_q     <= 32'h0;
            redirect_pc_q <= 32'h0;
            cur_level_q   <= LVL_USER;
            nest_err_q    <= 1'b0;
        end else begin
            if (exc_ignored) nest_err_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (ev_sel != EV_NONE) begin
                        ev_q        <= ev_sel;
                        cause_q     <= bus.exc_cause;
                        new_level_q <= (ev_sel == EV_EXC) ? LVL_EXC : irq_lvl;
                        if (ev_sel == EV_EXC)      cp0_epc_q <= bus.exc_pc + 32'd4;
                        else if (ev_sel == EV_IRQ) cp0_epc_q <= bus.int_pc;
                    end
                end
                ST_FLUSH: begin
                    redirect_pc_q <= (ev_q == EV_ERET) ? bus.epc_in : bus.handler_base;
                end
                ST_REDIRECT: begin
                    if (ev_q == EV_ERET) begin
                        if (stack_empty) begin
                            cur_level_q <= LVL_USER;
                            nest_err_q  <= 1'b1;
                        end else begin
                            cur_level_q <= stack_top;
                        end
                    end else begin
                        if (stack_full) nest_err_q <= 1'b1;
                        cur_level_q <= new_level_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: stimulus queues expected CP0 writes,
// redirects and resulting levels; a negedge monitor pops and compares them.
module tb_trap_sequencer;

    localparam int K_CP0 = 0;
    localparam int K_RDR = 1;
    localparam int K_LVL = 2;

    typedef struct {
        int          kind;
        logic [31:0] epc;
        logic [2:0]  cause;
        logic [2:0]  ack;
        logic [31:0] pc;
        logic [2:0]  level;
        logic        nerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks_total  = 0;
    int   checks_passed = 0;
    exp_t exp_q[$];
    bit   seen_rdr = 1'b0;

    trap_sequencer_if bus ();

    trap_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic exp_cp0(input logic [31:0] epc, input logic [2:0] cause, input logic [2:0] ack);
        exp_t e;
        e = '{kind: K_CP0, epc: epc, cause: cause, ack: ack, pc: 32'h0, level: 3'd0, nerr: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic exp_rdr(input logic [31:0] pc);
        exp_t e;
        e = '{kind: K_RDR, epc: 32'h0, cause: 3'd0, ack: 3'd0, pc: pc, level: 3'd0, nerr: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic exp_lvl(input logic [2:0] level, input logic nerr);
        exp_t e;
        e = '{kind: K_LVL, epc: 32'h0, cause: 3'd0, ack: 3'd0, pc: 32'h0, level: level, nerr: nerr};
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{kind: -1, epc: 32'h0, cause: 3'd0, ack: 3'd0, pc: 32'h0, level: 3'd0, nerr: 1'b0};
        if (exp_q.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL sequence: output kind %0d seen, expected nothing at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                checks_total++;
                $display("[TB] FAIL sequence: output kind %0d seen, expected kind %0d at %0t", kind, e.kind, $time);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: compares every strobe the DUT presents against the queue head.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen_rdr = 1'b0;
            end else begin
                if (seen_rdr) begin
                    pop_exp(K_LVL, e, ok);
                    if (ok) begin
                        checkOutput("cur_level", 32'(bus.cur_level), 32'(e.level));
                        checkOutput("nest_err", 32'(bus.nest_err), 32'(e.nerr));
                    end
                    seen_rdr = 1'b0;
                end
                if (bus.cp0_we) begin
                    pop_exp(K_CP0, e, ok);
                    if (ok) begin
                        checkOutput("cp0_epc", bus.cp0_epc, e.epc);
                        checkOutput("cp0_cause", 32'(bus.cp0_cause), 32'(e.cause));
                        checkOutput("irq_ack", 32'(bus.irq_ack), 32'(e.ack));
                        checkOutput("flush", 32'(bus.flush), 32'd1);
                    end
                end
                if (bus.redirect_valid) begin
                    pop_exp(K_RDR, e, ok);
                    if (ok) begin
                        checkOutput("redirect_pc", bus.redirect_pc, e.pc);
                        checkOutput("stall_rdr", 32'(bus.stall), 32'd1);
                    end
                    seen_rdr = 1'b1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic exc, input logic [2:0] cause, input logic [31:0] pc,
                                 input logic eret, input logic [2:0] irq, input logic irq_hold);
        bus.exc_valid = exc;
        bus.exc_cause = cause;
        bus.exc_pc    = pc;
        bus.eret_req  = eret;
        bus.irq_req   = irq;
        @(posedge clk);
        #1;
        bus.exc_valid = 1'b0;
        bus.eret_req  = 1'b0;
        if (!irq_hold) bus.irq_req = 3'b000;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.exc_valid    = 1'b0;
        bus.exc_cause    = 3'd0;
        bus.exc_pc       = 32'h0;
        bus.irq_req      = 3'b000;
        bus.int_pc       = 32'h0;
        bus.ie           = 1'b1;
        bus.eret_req     = 1'b0;
        bus.handler_base = 32'h24;
        bus.epc_in       = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_cur_level", 32'(bus.cur_level), 32'd0);
        checkOutput("reset_nest_err", 32'(bus.nest_err), 32'd0);
        checkOutput("reset_stall", 32'(bus.stall), 32'd0);
        checkOutput("reset_redirect_pc", bus.redirect_pc, 32'h0);
        checkOutput("reset_cp0_epc", bus.cp0_epc, 32'h0);
        idle_cycles(1);

        // Overflow exception at user level, then return.
        exp_cp0(32'h104, 3'd2, 3'b000); exp_rdr(32'h24); exp_lvl(3'd4, 1'b0);
        applyStimulus(1'b1, 3'd2, 32'h100, 1'b0, 3'b000, 1'b0);
        idle_cycles(4);
        bus.epc_in = 32'h104;
        exp_rdr(32'h104); exp_lvl(3'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'b000, 1'b0);
        idle_cycles(4);

        // Exception with interrupts/exceptions disabled is ignored.
        bus.ie = 1'b0;
        applyStimulus(1'b1, 3'd1, 32'h180, 1'b0, 3'b000, 1'b0);
        idle_cycles(4);
        checkOutput("ie0_cur_level", 32'(bus.cur_level), 32'd0);
        bus.ie = 1'b1;

        // Line 1 taken at level 0; line 0 afterwards is below the ring.
        bus.int_pc = 32'h40;
        exp_cp0(32'h40, 3'd0, 3'b010); exp_rdr(32'h24); exp_lvl(3'd2, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'b010, 1'b1);
        idle_cycles(4);
        bus.irq_req = 3'b001;
        idle_cycles(5);
        checkOutput("low_irq_level", 32'(bus.cur_level), 32'd2);
        checkOutput("low_irq_stall", 32'(bus.stall), 32'd0);
        bus.irq_req = 3'b000;
        bus.epc_in  = 32'h40;
        exp_rdr(32'h40); exp_lvl(3'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'b000, 1'b0);
        idle_cycles(4);

        // Simultaneous exception, ERET and interrupt: exception wins; the held
        // interrupt is taken right after the ERET brings the ring back to 0.
        bus.int_pc = 32'h500;
        exp_cp0(32'h304, 3'd1, 3'b000); exp_rdr(32'h24); exp_lvl(3'd4, 1'b0);
        applyStimulus(1'b1, 3'd1, 32'h300, 1'b1, 3'b100, 1'b1);
        idle_cycles(4);
        bus.epc_in = 32'h304;
        exp_rdr(32'h304); exp_lvl(3'd0, 1'b0);
        exp_cp0(32'h500, 3'd0, 3'b100); exp_rdr(32'h24); exp_lvl(3'd3, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'b100, 1'b1);
        idle_cycles(8);
        bus.irq_req = 3'b000;
        bus.epc_in  = 32'h500;
        exp_rdr(32'h500); exp_lvl(3'd0, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'b000, 1'b0);
        idle_cycles(4);

        // Fault while already at the exception level.
        exp_cp0(32'h704, 3'd4, 3'b000); exp_rdr(32'h24); exp_lvl(3'd4, 1'b0);
        applyStimulus(1'b1, 3'd4, 32'h700, 1'b0, 3'b000, 1'b0);
        idle_cycles(4);
        applyStimulus(1'b1, 3'd1, 32'h800, 1'b0, 3'b000, 1'b0);
        idle_cycles(4);
        checkOutput("l4_nest_err", 32'(bus.nest_err), 32'd1);
        checkOutput("l4_cur_level", 32'(bus.cur_level), 32'd4);
        checkOutput("l4_cp0_epc_hold", bus.cp0_epc, 32'h704);
        bus.epc_in = 32'h704;
        exp_rdr(32'h704); exp_lvl(3'd0, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'b000, 1'b0);
        idle_cycles(4);

        rst = 1'b1;
        #1;
        checkOutput("rst_clears_nest_err", 32'(bus.nest_err), 32'd0);
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(1);

        // Nest three interrupts, then unwind with one ERET too many.
        bus.epc_in = 32'h200;
        for (int i = 0; i < 3; i++) begin
            bus.int_pc = 32'h10 * (i + 1);
            exp_cp0(32'h10 * (i + 1), 3'd0, 3'(1 << i)); exp_rdr(32'h24); exp_lvl(3'(i + 1), 1'b0);
            applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'(1 << i), 1'b0);
            idle_cycles(4);
        end
        for (int i = 0; i < 4; i++) begin
            exp_rdr(32'h200);
            exp_lvl((i < 3) ? 3'(2 - i) : 3'd0, (i == 3) ? 1'b1 : 1'b0);
            applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'b000, 1'b0);
            idle_cycles(4);
        end

        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(1);

        // Reset arriving while the exception sequence is in FLUSH.
        bus.exc_valid = 1'b1;
        bus.exc_cause = 3'd4;
        bus.exc_pc    = 32'h900;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.exc_valid = 1'b0;
        #1;
        checkOutput("midseq_flush", 32'(bus.flush), 32'd0);
        checkOutput("midseq_cp0_we", 32'(bus.cp0_we), 32'd0);
        checkOutput("midseq_stall", 32'(bus.stall), 32'd0);
        checkOutput("midseq_cp0_epc", bus.cp0_epc, 32'h0);
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(4);
        checkOutput("midseq_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        checkOutput("midseq_cur_level", 32'(bus.cur_level), 32'd0);
        checkOutput("midseq_redirect_pc", bus.redirect_pc, 32'h0);

        idle_cycles(2);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
